// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with configurable data width, parity and stop bits
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   serial_rx  asynchronous serial line, idle high
//   m_data     received data, LSB = first data bit on the line
//   m_valid    m_data and flags hold an unconsumed frame
//   m_ready    consumer accepts the held frame when m_valid && m_ready
//   m_perr     parity error flag of the held frame
//   m_ferr     framing error flag of the held frame (a stop bit sampled 0)
//   m_break    break flag of the held frame (data, parity and first stop all 0)
//   overrun    one-cycle pulse: a completed frame was dropped
//   busy       receiver is inside a frame
module uart_rx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_perr,
    output logic                 m_ferr,
    output logic                 m_break,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DIV_W   = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TC_W    = $clog2(OVERSAMPLE);
    localparam int HALF    = OVERSAMPLE / 2;
    localparam int PAR     = (PARITY == 1 || PARITY == 2) ? PARITY : 0;
    localparam int NSTOP   = STOP_BITS == 2 ? 2 : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(OVERSAMPLE - 1);
    localparam logic [TC_W-1:0]  TC_S0    = TC_W'(HALF - 1);
    localparam logic [TC_W-1:0]  TC_S1    = TC_W'(HALF);
    localparam logic [TC_W-1:0]  TC_VOTE  = TC_W'(HALF + 1);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_sync;
    logic                  r_prev;
    logic [DIV_W-1:0]      r_div;
    logic [TC_W-1:0]       r_tc;
    logic                  r_s0, r_s1;
    logic [3:0]            r_bit;
    logic                  r_stop_idx;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_perr, r_ferr, r_pbit, r_stop0;
    logic                  w_rx, w_start, w_tick, w_vote_at, w_vote, w_bit_end;
    logic                  w_last_stop, w_done, w_ferr, w_break;

    assign w_rx        = r_sync[1];
    // r_prev only becomes 1 after a synced high, so a line stuck low never re-triggers
    assign w_start     = (r_state == S_IDLE) && r_prev && !w_rx;
    assign w_tick      = r_div == DIV_LAST;
    assign w_vote_at   = w_tick && (r_tc == TC_VOTE);
    // third sample is taken live at the vote tick
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_bit_end   = w_tick && (r_tc == TC_LAST);
    assign w_last_stop = r_stop_idx == 1'(NSTOP - 1);
    assign w_done      = (r_state == S_STOP) && w_vote_at && w_last_stop;
    assign w_ferr      = r_ferr | ~w_vote;
    assign w_break     = (r_shift == '0) && (PAR == 0 || !r_pbit) && (r_stop_idx ? r_stop0 : !w_vote);
    assign busy        = r_state != S_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
            r_div  <= '0;
        end else begin
            r_sync <= {r_sync[0], serial_rx};
            r_prev <= w_rx;
            r_div  <= (w_start || w_tick) ? '0 : r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_START;
            S_START:  if (w_vote_at && w_vote) w_next = S_IDLE;
                      else if (w_bit_end) w_next = S_DATA;
            S_DATA:   if (w_bit_end && r_bit == LAST_BIT) w_next = PAR != 0 ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_next = S_STOP;
            S_STOP:   if (w_done) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tc       <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_bit      <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_pbit     <= 1'b0;
            r_stop0    <= 1'b0;
        end else begin
            if (w_start) begin
                r_tc       <= '0;
                r_bit      <= '0;
                r_stop_idx <= 1'b0;
                r_perr     <= 1'b0;
                r_ferr     <= 1'b0;
                r_pbit     <= 1'b0;
                r_stop0    <= 1'b0;
            end else if (w_tick && r_state != S_IDLE) begin
                r_tc <= (r_tc == TC_LAST) ? '0 : r_tc + 1'b1;
            end
            if (w_tick && r_tc == TC_S0) r_s0 <= w_rx;
            if (w_tick && r_tc == TC_S1) r_s1 <= w_rx;
            if (w_vote_at && r_state == S_DATA) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (w_vote_at && r_state == S_PARITY) begin
                r_pbit <= w_vote;
                r_perr <= w_vote ^ (^r_shift) ^ (PAR == 2);
            end
            if (w_vote_at && r_state == S_STOP) begin
                if (!w_vote) r_ferr <= 1'b1;
                if (!r_stop_idx) r_stop0 <= !w_vote;
            end
            if (w_bit_end && r_state == S_DATA) r_bit <= r_bit + 4'd1;
            // only reachable with two stop bits: the single-stop frame completes at mid-bit
            if (w_bit_end && r_state == S_STOP) r_stop_idx <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_perr  <= 1'b0;
            m_ferr  <= 1'b0;
            m_break <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= w_done && m_valid && !m_ready;
            if (w_done && (!m_valid || m_ready)) begin
                m_valid <= 1'b1;
                m_data  <= r_shift;
                m_perr  <= r_perr;
                m_ferr  <= w_ferr;
                m_break <= w_break;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: table-driven, directed and randomized checks of uart_rx_param in four configurations
module tb_uart_rx_param;
    localparam int BCLK [4] = '{160, 160, 160, 32};
    localparam int ND   [4] = '{8, 7, 8, 9};
    localparam int PM   [4] = '{0, 1, 0, 2};
    localparam int NS   [4] = '{1, 1, 2, 2};

    typedef struct {int u; logic [8:0] d; logic p; logic f; logic b;} frame_t;
    typedef struct {int u; logic [8:0] d; logic pf; logic s1; logic s2; logic [8:0] ed; logic ep; logic ef; logic eb;} vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rx, rstn;
    logic [2:0] rdy;
    logic       rdy_d;
    logic [7:0] a_d;
    logic [6:0] b_d;
    logic [7:0] c_d;
    logic [8:0] d_d;
    logic a_v, a_p, a_f, a_b, a_o, a_y;
    logic b_v, b_p, b_f, b_b, b_o, b_y;
    logic c_v, c_p, c_f, c_b, c_o, c_y;
    logic d_v, d_p, d_f, d_b, d_o, d_y;

    frame_t q[$];
    int ovc[4];
    int vcyc[4];
    int n_chk = 0;
    int n_fail = 0;

    uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rstn[0]), .serial_rx(rx[0]), .m_data(a_d), .m_valid(a_v), .m_ready(rdy[0]),
        .m_perr(a_p), .m_ferr(a_f), .m_break(a_b), .overrun(a_o), .busy(a_y));
    uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rstn[1]), .serial_rx(rx[1]), .m_data(b_d), .m_valid(b_v), .m_ready(rdy[1]),
        .m_perr(b_p), .m_ferr(b_f), .m_break(b_b), .overrun(b_o), .busy(b_y));
    uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rstn[2]), .serial_rx(rx[2]), .m_data(c_d), .m_valid(c_v), .m_ready(rdy[2]),
        .m_perr(c_p), .m_ferr(c_f), .m_break(c_b), .overrun(c_o), .busy(c_y));
    uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(50_000), .OVERSAMPLE(8), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) u_d (
        .clk(clk), .rst(rstn[3]), .serial_rx(rx[3]), .m_data(d_d), .m_valid(d_v), .m_ready(rdy_d),
        .m_perr(d_p), .m_ferr(d_f), .m_break(d_b), .overrun(d_o), .busy(d_y));

    task automatic push(input int u, input logic [8:0] d, input logic p, input logic f, input logic b);
        frame_t fr;
        fr.u = u;
        fr.d = d;
        fr.p = p;
        fr.f = f;
        fr.b = b;
        q.push_back(fr);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ovc[i] = 0;
            vcyc[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (a_v && rdy[0]) push(0, {1'b0, a_d}, a_p, a_f, a_b);
            if (b_v && rdy[1]) push(1, {2'b0, b_d}, b_p, b_f, b_b);
            if (c_v && rdy[2]) push(2, {1'b0, c_d}, c_p, c_f, c_b);
            if (d_v && rdy_d)  push(3, d_d, d_p, d_f, d_b);
            ovc[0] += int'(a_o);
            ovc[1] += int'(b_o);
            ovc[2] += int'(c_o);
            ovc[3] += int'(d_o);
            vcyc[0] += int'(a_v);
        end
    end

    initial begin
        rdy_d = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_d = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serialize a frame onto line u; clocks in [gs, gs+gl) are inverted to model line noise.
    task automatic send(input int u, input logic [15:0] bits, input int n, input int gs, input int gl);
        for (int c = 0; c < n * BCLK[u]; c++) begin
            rx[u] = bits[c / BCLK[u]] ^ (c >= gs && c < gs + gl);
            clocks(1);
        end
        rx[u] = 1'b1;
    endtask

    // Line bits LSB first: start, data, optional parity (pf flips it), stop bit(s).
    function automatic logic [15:0] frm(input int u, input logic [8:0] d, input logic pf,
                                        input logic s1, input logic s2, output int n);
        logic [15:0] f;
        logic par;
        f = '1;
        par = 1'b0;
        f[0] = 1'b0;
        n = 1;
        for (int i = 0; i < ND[u]; i++) begin
            f[n] = d[i];
            par ^= d[i];
            n++;
        end
        if (PM[u] != 0) begin
            f[n] = par ^ (PM[u] == 2) ^ pf;
            n++;
        end
        f[n] = s1;
        n++;
        if (NS[u] == 2) begin
            f[n] = s2;
            n++;
        end
        return f;
    endfunction

    task automatic expect_frame(input string nm, input int u, input logic [8:0] d,
                                input logic p, input logic f, input logic b);
        frame_t fr;
        int t;
        t = 0;
        while (q.size() == 0 && t < 4000) begin
            clocks(1);
            t++;
        end
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no frame within 4000 clocks, expected data 0x%0h", nm, d);
            return;
        end
        fr = q.pop_front();
        chk({nm, ".unit"}, fr.u, u);
        chk({nm, ".data"}, fr.d, d);
        chk({nm, ".perr"}, fr.p, p);
        chk({nm, ".ferr"}, fr.f, f);
        chk({nm, ".break"}, fr.b, b);
    endtask

    initial begin
        vec_t tbl[13];
        logic [15:0] bits;
        logic [8:0] rd;
        logic rpf, rs1, rs2, ep, ef, eb, x;
        int n, v0, o0;
        tbl[0]  = '{0, 9'h03C, 1'b0, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{0, 9'h080, 1'b0, 1'b0, 1'b1, 9'h080, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1, 9'h055, 1'b0, 1'b1, 1'b1, 9'h055, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1, 9'h055, 1'b1, 1'b1, 1'b1, 9'h055, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1, 9'h000, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1, 9'h000, 1'b1, 1'b0, 1'b1, 9'h000, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1, 9'h07F, 1'b0, 1'b1, 1'b1, 9'h07F, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1, 9'h07F, 1'b1, 1'b1, 1'b1, 9'h07F, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{2, 9'h03C, 1'b0, 1'b1, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{2, 9'h000, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};

        rx = '1;
        rstn = '0;
        rdy = '1;
        clocks(5);
        chk("reset.valid", a_v, 0);
        chk("reset.data", a_d, 0);
        chk("reset.perr", a_p, 0);
        chk("reset.ferr", a_f, 0);
        chk("reset.break", a_b, 0);
        chk("reset.overrun", a_o, 0);
        chk("reset.busy", a_y, 0);
        rstn = '1;
        clocks(20);

        v0 = vcyc[0];
        bits = frm(0, 9'h0A5, 1'b0, 1'b1, 1'b1, n);
        send(0, bits, n, -1, 0);
        chk("a5.busy_after_stop", a_y, 0);
        clocks(10);
        expect_frame("a5", 0, 9'h0A5, 1'b0, 1'b0, 1'b0);
        chk("a5.valid_cycles", vcyc[0] - v0, 1);

        // one-sample glitch on data bit 0 must be outvoted
        send(0, bits, n, 160 + 86, 9);
        clocks(10);
        expect_frame("vote", 0, 9'h0A5, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            bits = frm(tbl[i].u, tbl[i].d, tbl[i].pf, tbl[i].s1, tbl[i].s2, n);
            send(tbl[i].u, bits, n, -1, 0);
            clocks(40);
            expect_frame($sformatf("vec%0d", i), tbl[i].u, tbl[i].ed, tbl[i].ep, tbl[i].ef, tbl[i].eb);
        end

        rx[0] = 1'b0;
        clocks(12 * 160);
        rx[0] = 1'b1;
        clocks(2 * 160);
        expect_frame("break", 0, 9'h000, 1'b0, 1'b1, 1'b1);
        chk("break.single_frame", q.size(), 0);
        bits = frm(0, 9'h05A, 1'b0, 1'b1, 1'b1, n);
        send(0, bits, n, -1, 0);
        clocks(10);
        expect_frame("after_break", 0, 9'h05A, 1'b0, 1'b0, 1'b0);

        rdy[0] = 1'b0;
        o0 = ovc[0];
        bits = frm(0, 9'h011, 1'b0, 1'b1, 1'b1, n);
        send(0, bits, n, -1, 0);
        clocks(20);
        bits = frm(0, 9'h022, 1'b0, 1'b1, 1'b1, n);
        send(0, bits, n, -1, 0);
        clocks(20);
        chk("ovr.valid_held", a_v, 1);
        chk("ovr.data_held", a_d, 8'h11);
        chk("ovr.pulse_count", ovc[0] - o0, 1);
        chk("ovr.nothing_taken", q.size(), 0);
        rdy[0] = 1'b1;
        clocks(3);
        expect_frame("ovr.held", 0, 9'h011, 1'b0, 1'b0, 1'b0);
        chk("ovr.valid_dropped", a_v, 0);
        chk("ovr.no_second", q.size(), 0);

        rx[0] = 1'b0;
        clocks(30);
        rx[0] = 1'b1;
        chk("glitch.busy_during", a_y, 1);
        clocks(120);
        chk("glitch.busy_after", a_y, 0);
        chk("glitch.no_valid", a_v, 0);
        chk("glitch.flags", {a_p, a_f, a_b}, 0);
        chk("glitch.no_frame", q.size(), 0);

        bits = frm(2, 9'h0FF, 1'b0, 1'b1, 1'b1, n);
        send(2, bits, n, -1, 0);
        bits = frm(2, 9'h000, 1'b0, 1'b1, 1'b1, n);
        send(2, bits, n, -1, 0);
        bits = frm(2, 9'h081, 1'b0, 1'b1, 1'b1, n);
        send(2, bits, n, -1, 0);
        clocks(20);
        expect_frame("b2b0", 2, 9'h0FF, 1'b0, 1'b0, 1'b0);
        expect_frame("b2b1", 2, 9'h000, 1'b0, 1'b0, 1'b0);
        expect_frame("b2b2", 2, 9'h081, 1'b0, 1'b0, 1'b0);

        // reset lands in the zero data bits and releases in the ones, so no edge follows
        bits = frm(2, 9'h0F0, 1'b0, 1'b1, 1'b1, n);
        fork
            send(2, bits, n, -1, 0);
            begin
                clocks(560);
                chk("rst.busy_before", c_y, 1);
                rstn[2] = 1'b0;
                #1;
                chk("rst.valid", c_v, 0);
                chk("rst.data", c_d, 0);
                chk("rst.perr", c_p, 0);
                chk("rst.ferr", c_f, 0);
                chk("rst.break", c_b, 0);
                chk("rst.overrun", c_o, 0);
                chk("rst.busy", c_y, 0);
                clocks(480);
                rstn[2] = 1'b1;
            end
        join
        clocks(200);
        chk("rst.no_frame", q.size(), 0);
        chk("rst.idle", c_y, 0);
        bits = frm(2, 9'h081, 1'b0, 1'b1, 1'b1, n);
        send(2, bits, n, -1, 0);
        clocks(20);
        expect_frame("rst.recover", 2, 9'h081, 1'b0, 1'b0, 1'b0);

        // reference model judges each frame purely from the line bits
        for (int i = 0; i < 40; i++) begin
            rd  = (i % 10 == 3) ? 9'h000 : 9'($urandom_range(0, 511));
            rpf = $urandom_range(0, 3) == 0;
            rs1 = (i % 10 == 3) ? 1'b0 : ($urandom_range(0, 5) != 0);
            rs2 = $urandom_range(0, 5) != 0;
            bits = frm(3, rd, rpf, rs1, rs2, n);
            x = 1'b0;
            for (int j = 1; j <= 10; j++) x ^= bits[j];
            ep = x != 1'b1;
            ef = !bits[11] || !bits[12];
            eb = 1'b1;
            for (int j = 1; j <= 11; j++) if (bits[j]) eb = 1'b0;
            send(3, bits, n, -1, 0);
            clocks($urandom_range(4, 40));
            expect_frame($sformatf("rnd%0d", i), 3, rd, ep, ef, eb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
